// File: rtl/inv_subbytes_seq.sv
`default_nettype none
// ============================================================================
// Module   : inv_subbytes_seq (with helper module isbox)
// Brief    : Sequential AES InvSubBytes over a 128-bit state. BPC bytes are
//            substituted per clock, so a block takes N = 16/BPC cycles.
//            Handshakes are valid/ready on both input and output sides.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// isbox: AES inverse S-box. Undo the affine transform, then take the
// multiplicative inverse in GF(2^8) as x^254 (which maps 0 to 0 naturally).
// ----------------------------------------------------------------------------
module isbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] w_aff;
  logic [7:0] w_p2, w_p3, w_p6, w_p12, w_p15;
  logic [7:0] w_p30, w_p60, w_p120, w_p240, w_p252, w_p254;

  // Inverse affine map followed by an addition chain for x^254
  always_comb begin
    w_aff  = {a_i[6:0], a_i[7]} ^ {a_i[4:0], a_i[7:5]} ^ {a_i[1:0], a_i[7:2]} ^ 8'h05;
    w_p2   = gf_mul(w_aff, w_aff);
    w_p3   = gf_mul(w_p2, w_aff);
    w_p6   = gf_mul(w_p3, w_p3);
    w_p12  = gf_mul(w_p6, w_p6);
    w_p15  = gf_mul(w_p12, w_p3);
    w_p30  = gf_mul(w_p15, w_p15);
    w_p60  = gf_mul(w_p30, w_p30);
    w_p120 = gf_mul(w_p60, w_p60);
    w_p240 = gf_mul(w_p120, w_p120);
    w_p252 = gf_mul(w_p240, w_p12);
    w_p254 = gf_mul(w_p252, w_p2);
  end

  assign y_o = w_p254;

endmodule

// ----------------------------------------------------------------------------
// inv_subbytes_seq: top level
// ----------------------------------------------------------------------------
module inv_subbytes_seq #(
  parameter int BPC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int N  = 16 / BPC;
  localparam int LB = $clog2(BPC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [15:0][7:0]  work_q, work_d;

  logic [BPC-1:0][3:0] w_idx;
  logic [BPC-1:0][7:0] w_sb_in;
  logic [BPC-1:0][7:0] w_sb_out;

  // One S-box per lane; lane k serves byte cnt*BPC + k of the work register.
  // The low LB bits of the shifted counter are zero, so OR-ing k is an add.
  generate
    for (genvar k = 0; k < BPC; k++) begin : g_lane
      assign w_idx[k]   = (cnt_q << LB) | 4'(k);
      assign w_sb_in[k] = work_q[w_idx[k]];
      isbox u_isbox (
        .a_i (w_sb_in[k]),
        .y_o (w_sb_out[k])
      );
    end
  endgenerate

  // State, counter and work register; reset clears everything immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  // Next-state, datapath update and handshake outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_data;
          cnt_d   = 4'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int k = 0; k < BPC; k++) begin
          work_d[w_idx[k]] = w_sb_out[k];
        end
        if (cnt_q == 4'(N - 1)) begin
          cnt_d   = 4'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign out_data = work_q;
  assign busy     = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_inv_subbytes_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_subbytes_seq
// Brief    : Runs five instances (BPC = 1, 2, 4, 8, 16) on shared stimulus and
//            checks every cycle against a block-level model built from a
//            forward S-box table inverted by search.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inv_subbytes_seq;

  localparam int NI = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;

  logic [NI-1:0] in_ready_a;
  logic [NI-1:0] out_valid_a;
  logic [NI-1:0] busy_a;
  logic [127:0]  out_data_a [NI];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] isb_t [256];

  // model: phase 0 idle, 1 run, 2 done; k = groups already substituted
  int           m_phase [NI];
  int           m_k     [NI];
  logic [127:0] m_cap   [NI];

  bit run_cmp     = 1'b0;
  bit stream_mode = 1'b0;
  int cyc         = 0;
  int last_acc [NI];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      inv_subbytes_seq #(.BPC(1 << g)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a[g]),
        .in_data   (in_data),
        .out_valid (out_valid_a[g]),
        .out_ready (out_ready),
        .out_data  (out_data_a[g]),
        .busy      (busy_a[g])
      );
    end
  endgenerate

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // expected state after k groups of bpc bytes have been substituted
  function automatic logic [127:0] exp_out(input logic [127:0] cap, input int k, input int bpc);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) begin
      if (b < k * bpc) r[8*b +: 8] = isb_t[cap[8*b +: 8]];
      else             r[8*b +: 8] = cap[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string nm, input int idx, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // behavioural model of each instance
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_phase[i] <= 0;
        m_k[i]     <= 0;
        m_cap[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        case (m_phase[i])
          0: if (in_valid) begin
               m_cap[i]   <= in_data;
               m_k[i]     <= 0;
               m_phase[i] <= 1;
             end
          1: begin
               m_k[i] <= m_k[i] + 1;
               if (m_k[i] + 1 == (16 >> i)) m_phase[i] <= 2;
             end
          default: if (out_ready) m_phase[i] <= 0;
        endcase
      end
    end
  end

  // per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    if (run_cmp) begin
      cyc++;
      for (int i = 0; i < NI; i++) begin
        chk("in_ready",  i, in_ready_a[i],  m_phase[i] == 0);
        chk("out_valid", i, out_valid_a[i], m_phase[i] == 2);
        chk("busy",      i, busy_a[i],      m_phase[i] != 0);
        chk("out_data",  i, out_data_a[i],  exp_out(m_cap[i], m_k[i], 1 << i));
        if (!stream_mode) begin
          last_acc[i] = -1;
        end else if (in_valid && in_ready_a[i]) begin
          if (last_acc[i] >= 0) chk("accept_spacing", i, cyc - last_acc[i], (16 >> i) + 2);
          last_acc[i] = cyc;
        end
      end
    end
  end

  task automatic send(input logic [127:0] d);
    @(posedge clk); #1;
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] inv;
    logic [7:0] fwd;
    // inverse S-box by search: forward S-box of every x, then invert the map
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      fwd = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      isb_t[fwd] = 8'(x);
    end
    chk("isb_63", 0, isb_t[8'h63], 8'h00);
    chk("isb_FF", 0, isb_t[8'hFF], 8'h7D);
    chk("isb_01", 0, isb_t[8'h01], 8'h09);
    chk("isb_00", 0, isb_t[8'h00], 8'h52);
    chk("isb_0F", 0, isb_t[8'h0F], 8'hFB);

    // reset
    #1 rst_n = 1'b0;
    run_cmp = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_out_data",  i, out_data_a[i],  128'h0);
      chk("rst_in_ready",  i, in_ready_a[i],  1'b1);
      chk("rst_out_valid", i, out_valid_a[i], 1'b0);
      chk("rst_busy",      i, busy_a[i],      1'b0);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    // ascending bytes 00..0F, input scrambled after accept
    send(128'h0F0E0D0C0B0A09080706050403020100);
    repeat (20) begin
      @(posedge clk); #1 in_data = rnd128();
    end
    for (int i = 0; i < NI; i++) begin
      chk("vec_asc", i, out_data_a[i], 128'hFBD7F3819EA340BF38A53630D56A0952);
      chk("vec_asc_ov", i, out_valid_a[i], 1'b1);
    end
    drain();

    // all 63 -> all 00, with exact latency per instance
    send({16{8'h63}});
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1 in_data = rnd128();
      for (int i = 0; i < NI; i++)
        chk("latency_ov", i, out_valid_a[i], k >= (16 >> i));
    end
    for (int i = 0; i < NI; i++) chk("vec_63", i, out_data_a[i], 128'h0);
    drain();

    // all FF -> all 7D, held in DONE with in_valid pushing new data
    send({16{8'hFF}});
    in_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1 in_data = rnd128();
      if (c >= 20) begin
        for (int i = 0; i < NI; i++) begin
          chk("hold_data", i, out_data_a[i], {16{8'h7D}});
          chk("hold_ov",   i, out_valid_a[i], 1'b1);
          chk("hold_ir",   i, in_ready_a[i],  1'b0);
        end
      end
    end
    in_valid = 1'b0;
    drain();

    // reset in the middle of a block
    send(rnd128());
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("midrst_ir",   i, in_ready_a[i],  1'b1);
      chk("midrst_ov",   i, out_valid_a[i], 1'b0);
      chk("midrst_data", i, out_data_a[i],  128'h0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) chk("midrst_no_ov", i, out_valid_a[i], 1'b0);
    end

    // back-to-back stream
    stream_mode = 1'b1;
    in_valid    = 1'b1;
    repeat (150) begin
      @(posedge clk); #1 in_data = rnd128();
    end
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 stream_mode = 1'b0;

    // all 01 captured, input churning afterwards -> all 09
    out_ready = 1'b0;
    send({16{8'h01}});
    repeat (20) begin
      @(posedge clk); #1 in_data = rnd128();
    end
    for (int i = 0; i < NI; i++) chk("vec_01", i, out_data_a[i], {16{8'h09}});
    drain();
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inv_subbytes_seq.md
INV_SUBBYTES_SEQ -- requirements
Module: inv_subbytes_seq

Interface
REQ-001 SHALL have parameter BPC, default 1: bytes substituted per cycle; legal values 1, 2, 4, 8, 16; other values unsupported.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1: in_data holds a 128-bit block to inverse-substitute.
REQ-005 SHALL have port in_ready, output, 1: block can accept input.
REQ-006 SHALL have port in_data, input, 128: input state; byte i = in_data[8i+7:8i], i=0..15.
REQ-007 SHALL have port out_valid, output, 1: out_data holds a finished block.
REQ-008 SHALL have port out_ready, input, 1: consumer accepts out_data.
REQ-009 SHALL have port out_data, output, 128: result state, same byte ordering as in_data.
REQ-010 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-011 SHALL instantiate exactly BPC isbox instances (AES inverse S-box, 8-bit in/out) and no other substitution logic.
REQ-012 SHALL hold a 128-bit work register; out_data SHALL equal the work register at all times.
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; N = 16/BPC; 4-bit byte-group counter cnt.
REQ-014 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, work register <= in_data, cnt <= 0, next state RUN.
REQ-015 IDLE with in_valid=0: no register changes.
REQ-016 RUN: in_ready=0, out_valid=0; each cycle bytes cnt*BPC .. cnt*BPC+BPC-1 of the work register are replaced by their isbox outputs; other bytes held.
REQ-017 RUN: cnt increments by 1 per cycle; on the cycle cnt==N-1, the final group is written, cnt <= 0, next state DONE.
REQ-018 RUN SHALL NOT stall; in_valid and out_ready are ignored in RUN.
REQ-019 DONE: out_valid=1, in_ready=0; out_data stable until handshake; on out_ready=1, next state IDLE.
REQ-020 DONE with out_ready=0: state, work register and out_data held indefinitely.
REQ-021 in_ready SHALL be 1 only in IDLE; no input accepted in the cycle of an output handshake.
REQ-022 Latency: accept at edge E; out_valid first high after edge E+N; one block per N+2 cycles max throughput with out_ready tied high.
REQ-023 Each byte SHALL be substituted exactly once per block; no byte of a new block is touched before acceptance.
REQ-024 in_data changes while in_ready=0 SHALL have no effect.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, cnt=0, work register=0, independent of clk.
REQ-026 During and after reset: in_ready=1, out_valid=0, busy=0, out_data=128'h0.
REQ-027 Reset asserted in RUN or DONE SHALL discard the in-flight block; no out_valid pulse for it after release.
REQ-028 First accept permitted on the first rising edge with rst_n high.

Verification
REQ-029 BPC=1, in_data=128'h0F0E0D0C0B0A09080706050403020100 -> after 16 cycles out_valid=1, out_data=128'hFBD7F3819EA340BF38A53630D56A0952.
REQ-030 BPC=4, in_data all bytes 8'h63 -> out_valid high exactly 4 edges after accept, out_data=128'h0.
REQ-031 BPC=16, in_data all bytes 8'hFF -> out_valid after 1 edge, out_data all bytes 8'h7D; out_ready held 0 for 10 cycles -> out_data/out_valid stable, in_ready=0.
REQ-032 BPC=2, rst_n pulsed low at cnt=3 in RUN -> in_ready=1, out_valid=0, out_data=0 immediately; no later out_valid without new accept.
REQ-033 Any BPC, in_valid held high, out_ready high, stream of blocks -> accepts spaced N+2 cycles apart, in_ready=0 outside IDLE, each result matches per-byte isbox reference model.
REQ-034 BPC=8, in_data changed every cycle during RUN -> result depends only on value captured at accept (e.g. captured bytes 8'h01 -> all bytes 8'h09).
